// File: rtl/rf_writeback_arbiter.sv
// Shares the RV32I register-file write port between ALU and LSU writeback, tracks pending
// load destinations for decode hazards. Define RF_WB_RR_EN for round-robin arbitration.
module rf_writeback_arbiter #(
  parameter int W          = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic [4:0]   alu_rd,
  input  logic [W-1:0] alu_wd,
  input  logic         lsu_valid,
  output logic         lsu_ready,
  input  logic [4:0]   lsu_rd,
  input  logic [W-1:0] lsu_wd,
  input  logic         ld_issue,
  input  logic [4:0]   ld_rd,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  output logic         hazard,
  output logic [31:0]  busy,
  output logic         rf_we,
  output logic [4:0]   rf_rd,
  output logic [W-1:0] rf_wd
);

  logic [31:0]  busy_reg, busy_next;
  logic         rf_we_reg;
  logic [4:0]   rf_rd_reg;
  logic [W-1:0] rf_wd_reg;

  logic alu_elig, lsu_elig, contend, lsu_wins;
  logic grant_alu, grant_lsu;

`ifdef RF_WB_RR_EN
  // Set when the last contended grant went to the ALU, so the LSU wins the next one.
  logic rr_lsu_first_reg, rr_lsu_first_next;
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
`endif

  // ALU is held off while its destination still has a load outstanding (WAW).
  always_comb begin
    alu_elig = rst && alu_valid && !((alu_rd != 5'd0) && busy_reg[alu_rd]);
    lsu_elig = rst && lsu_valid;
    contend  = alu_elig && lsu_elig;
`ifdef RF_WB_RR_EN
    lsu_wins = rr_lsu_first_reg;
`else
    lsu_wins = (starve_cnt_reg == STARVE_LIM);
`endif
    grant_lsu = lsu_elig && (!alu_elig || lsu_wins);
    grant_alu = alu_elig && !grant_lsu;
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

`ifdef RF_WB_RR_EN
  always_comb begin
    rr_lsu_first_next = rr_lsu_first_reg;
    if (contend) rr_lsu_first_next = grant_alu;
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_lsu_first_reg <= 1'b0;
    else      rr_lsu_first_reg <= rr_lsu_first_next;
  end
`else
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!lsu_valid || grant_lsu)
      starve_cnt_next = '0;
    else if (starve_cnt_reg != STARVE_LIM)
      starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_cnt_reg <= '0;
    else      starve_cnt_reg <= starve_cnt_next;
  end
`endif

  // Clear first, then set, so a load issued the same cycle its predecessor retires stays pending.
  always_comb begin
    busy_next = busy_reg;
    if (grant_lsu && (lsu_rd != 5'd0)) busy_next[lsu_rd] = 1'b0;
    if (ld_issue && (ld_rd != 5'd0))   busy_next[ld_rd]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg  <= '0;
      rf_we_reg <= 1'b0;
      rf_rd_reg <= '0;
      rf_wd_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      rf_we_reg <= 1'b0;
      if (grant_lsu) begin
        rf_we_reg <= (lsu_rd != 5'd0);
        rf_rd_reg <= lsu_rd;
        rf_wd_reg <= lsu_wd;
      end else if (grant_alu) begin
        rf_we_reg <= (alu_rd != 5'd0);
        rf_rd_reg <= alu_rd;
        rf_wd_reg <= alu_wd;
      end
    end
  end

  assign busy  = busy_reg;
  assign rf_we = rf_we_reg;
  assign rf_rd = rf_rd_reg;
  assign rf_wd = rf_wd_reg;

  logic [4:0] src [2];
  logic [1:0] src_haz;
  assign src[0] = rs1;
  assign src[1] = rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_haz[gi] = (src[gi] != 5'd0) &&
                         (busy_reg[src[gi]] || (rf_we_reg && (rf_rd_reg == src[gi])));
  end

  assign hazard = |src_haz;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized and directed bench for rf_writeback_arbiter against a cycle-level reference model.
module tb_rf_writeback_arbiter;
  localparam int W          = 32;
  localparam int STARVE_MAX = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         alu_valid = 1'b0, lsu_valid = 1'b0, ld_issue = 1'b0;
  logic [4:0]   alu_rd = '0, lsu_rd = '0, ld_rd = '0, rs1 = '0, rs2 = '0;
  logic [W-1:0] alu_wd = '0, lsu_wd = '0;
  logic         alu_ready, lsu_ready, hazard, rf_we;
  logic [31:0]  busy;
  logic [4:0]   rf_rd;
  logic [W-1:0] rf_wd;

  int n_vec = 0;
  int n_bad = 0;

  rf_writeback_arbiter #(.W(W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .rs1(rs1), .rs2(rs2),
    .hazard(hazard), .busy(busy), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending-load set, expected write for the current cycle, LSU wait count,
  // and which channel took the most recent contended grant (0 = ALU, 1 = LSU).
  bit          m_busy [32];
  bit          m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;
  int          m_wait = 0;
  int          m_last = 1;
  bit          m_alu_gnt = 1'b0, m_lsu_gnt = 1'b0;

  always @(negedge clk) begin
    bit          a_ok, l_ok, l_win, a_g, l_g, h;
    logic [31:0] busy_vec;
    a_ok = rst && alu_valid && !(alu_rd != 0 && m_busy[alu_rd]);
    l_ok = rst && lsu_valid;
    if (a_ok && l_ok) begin
`ifdef RF_WB_RR_EN
      l_win = (m_last == 0);
`else
      l_win = (m_wait >= STARVE_MAX);
`endif
    end else begin
      l_win = l_ok;
    end
    l_g = l_win;
    a_g = a_ok && !l_win;

    h = 1'b0;
    if (rs1 != 0 && (m_busy[rs1] || (m_we && m_rd == rs1))) h = 1'b1;
    if (rs2 != 0 && (m_busy[rs2] || (m_we && m_rd == rs2))) h = 1'b1;
    for (int i = 0; i < 32; i++) busy_vec[i] = m_busy[i];

    check("alu_ready", {31'd0, alu_ready}, {31'd0, a_g});
    check("lsu_ready", {31'd0, lsu_ready}, {31'd0, l_g});
    check("hazard", {31'd0, hazard}, {31'd0, h});
    check("busy", busy, busy_vec);
    check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    if (m_we) begin
      check("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
      check("rf_wd", rf_wd, m_wd);
    end

    m_alu_gnt = a_g;
    m_lsu_gnt = l_g;
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_we = 0; m_rd = '0; m_wd = '0; m_wait = 0; m_last = 1;
    end else begin
      m_we = 1'b0;
      if (l_g) begin
        m_we = (lsu_rd != 0); m_rd = lsu_rd; m_wd = lsu_wd;
        if (lsu_rd != 0) m_busy[lsu_rd] = 1'b0;
      end else if (a_g) begin
        m_we = (alu_rd != 0); m_rd = alu_rd; m_wd = alu_wd;
      end
      if (ld_issue && ld_rd != 0) m_busy[ld_rd] = 1'b1;
      m_wait = (lsu_valid && !l_g) ? m_wait + 1 : 0;
      if (a_ok && l_ok) m_last = l_g ? 1 : 0;
    end
  end

  initial begin
    bit exp_l;
    // Reset with both requesters asserting valid.
    rst = 1'b0; alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd1; lsu_rd = 5'd2;
    @(negedge clk);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    @(negedge clk);
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_hazard", {31'd0, hazard}, 32'd0);
    tick(); rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;

    // Continuous contention.
    tick(); alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'hA1A1_0001;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wd = 32'h1515_0002;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
`ifdef RF_WB_RR_EN
      exp_l = (i % 2 == 1);
`else
      exp_l = (i % (STARVE_MAX + 1) == STARVE_MAX);
`endif
      check("contend_alu", {31'd0, alu_ready}, {31'd0, !exp_l});
      check("contend_lsu", {31'd0, lsu_ready}, {31'd0, exp_l});
      tick();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // Single ALU write, then RAW on the in-flight write.
    tick(); alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEAD_BEEF;
    @(negedge clk); check("alu_single_ready", {31'd0, alu_ready}, 32'd1);
    tick(); alu_valid = 1'b0; rs1 = 5'd5;
    @(negedge clk);
    check("alu_single_we", {31'd0, rf_we}, 32'd1);
    check("alu_single_rd", {27'd0, rf_rd}, 32'd5);
    check("alu_single_wd", rf_wd, 32'hDEAD_BEEF);
    check("alu_single_hazard", {31'd0, hazard}, 32'd1);
    tick(); rs1 = 5'd0;

    // Load flow on x7.
    ld_issue = 1'b1; ld_rd = 5'd7;
    tick(); ld_issue = 1'b0; rs2 = 5'd7;
    @(negedge clk);
    check("load_busy_set", {31'd0, busy[7]}, 32'd1);
    check("load_hazard_pending", {31'd0, hazard}, 32'd1);
    tick(); lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h0000_1234;
    @(negedge clk); check("load_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    tick(); lsu_valid = 1'b0;
    @(negedge clk);
    check("load_busy_clear", {31'd0, busy[7]}, 32'd0);
    check("load_hazard_write", {31'd0, hazard}, 32'd1);
    tick();
    @(negedge clk); check("load_hazard_done", {31'd0, hazard}, 32'd0);
    tick(); rs2 = 5'd0;

    // WAW on x3: ALU waits for the load to retire.
    ld_issue = 1'b1; ld_rd = 5'd3;
    tick(); ld_issue = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h0000_AAAA;
    @(negedge clk); check("waw_alu_blocked0", {31'd0, alu_ready}, 32'd0);
    tick();
    @(negedge clk); check("waw_alu_blocked1", {31'd0, alu_ready}, 32'd0);
    tick(); lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wd = 32'h0000_BBBB;
    @(negedge clk);
    check("waw_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("waw_alu_blocked2", {31'd0, alu_ready}, 32'd0);
    tick(); lsu_valid = 1'b0;
    @(negedge clk);
    check("waw_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("waw_first_wd", rf_wd, 32'h0000_BBBB);
    tick(); alu_valid = 1'b0;
    @(negedge clk);
    check("waw_second_we", {31'd0, rf_we}, 32'd1);
    check("waw_second_wd", rf_wd, 32'h0000_AAAA);

    // x0 destination accepted without a write.
    tick(); alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFFFF_FFFF;
    @(negedge clk); check("x0_ready", {31'd0, alu_ready}, 32'd1);
    tick(); alu_valid = 1'b0;
    @(negedge clk); check("x0_no_we", {31'd0, rf_we}, 32'd0);

    // Reissue to x9 in the same cycle the previous x9 load retires.
    tick(); ld_issue = 1'b1; ld_rd = 5'd9;
    tick(); lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h0000_0009;
    @(negedge clk); check("setclr_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    tick(); ld_issue = 1'b0; lsu_valid = 1'b0;
    @(negedge clk); check("setclr_busy9", {31'd0, busy[9]}, 32'd1);

    // Randomized traffic with occasional mid-run resets; requests hold until accepted.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) != 0);
      if (!alu_valid || m_alu_gnt) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_wd    = $urandom;
      end
      if (!lsu_valid || m_lsu_gnt) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd    = 5'($urandom_range(0, 9));
        lsu_wd    = $urandom;
      end
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_rd    = 5'($urandom_range(0, 9));
      rs1      = 5'($urandom_range(0, 9));
      rs2      = 5'($urandom_range(0, 9));
    end
    tick(); rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; ld_issue = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
